// File: rtl/snake_pkg.sv
// Shared encodings for the snake game controller and the snake_field datapath.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam int INIT_LEN = 4;

    // Returns {valid, dir}; up beats right beats down beats left.
    function automatic logic [2:0] dir_request(input logic up, input logic right,
                                               input logic down, input logic left);
        logic [2:0] req;
        req = 3'b000;
        if (up)         req = {1'b1, DIR_UP};
        else if (right) req = {1'b1, DIR_RIGHT};
        else if (down)  req = {1'b1, DIR_DOWN};
        else if (left)  req = {1'b1, DIR_LEFT};
        return req;
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Step pacing timer: counts run cycles, expires at period-1, reloads its period from
// the current snake length so the game speeds up as the snake grows.
module snake_step_timer
    import snake_pkg::*;
#(
    parameter int          SBITS       = 7,
    parameter logic [23:0] BASE_PERIOD = 24'd5000000,
    parameter logic [23:0] SPEEDUP     = 24'd100000,
    parameter logic [23:0] MIN_PERIOD  = 24'd1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [SBITS-1:0] snake_len,
    output logic             expire
);

    logic [23:0]      timer_q, timer_d;
    logic [23:0]      period_q, period_d;
    logic [SBITS-1:0] extra;
    logic [31:0]      dec;
    logic [23:0]      raw;
    logic [23:0]      period_calc;

    // Saturating period: never underflows below zero, then floored at MIN_PERIOD.
    always_comb begin
        extra = (snake_len > SBITS'(INIT_LEN)) ? snake_len - SBITS'(INIT_LEN) : '0;
        dec   = 32'(SPEEDUP) * 32'(extra);
        raw   = (dec >= 32'(BASE_PERIOD)) ? 24'd0 : BASE_PERIOD - dec[23:0];
        period_calc = (raw < MIN_PERIOD) ? MIN_PERIOD : raw;
    end

    assign expire = run && (timer_q == period_q - 24'd1);

    always_comb begin
        timer_d  = timer_q;
        period_d = period_q;
        if (clear || expire) begin
            timer_d  = '0;
            period_d = period_calc;
        end else if (run) begin
            timer_d = timer_q + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q  <= '0;
            period_q <= BASE_PERIOD;
        end else begin
            timer_q  <= timer_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer for snake_field: start/step pulses, held direction, death detection,
// apple seed and score tracking.
//   state    | meaning
//   ST_IDLE  | after reset, waiting for the first start press
//   ST_RUN   | game running, timer paces steps, direction buttons live
//   ST_PAUSE | timer frozen, buttons ignored until the next start press
//   ST_OVER  | snake died, score frozen, start press begins a new game
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int          SIZE_X      = 10,
    parameter int          SIZE_Y      = 10,
    parameter int          SBITS       = $clog2(SIZE_X*SIZE_Y),
    parameter logic [23:0] BASE_PERIOD = 24'd5000000,
    parameter logic [23:0] SPEEDUP     = 24'd100000,
    parameter logic [23:0] MIN_PERIOD  = 24'd1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_right,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_start,
    input  logic             snake_alive,
    input  logic [SBITS-1:0] snake_len,
    output logic             start,
    output logic             step,
    output logic [1:0]       snake_dir,
    output logic [SBITS-1:0] seed,
    output logic [1:0]       state,
    output logic [SBITS-1:0] score,
    output logic [SBITS-1:0] best
);

    localparam int CELLS = SIZE_X * SIZE_Y;

    state_e           state_q, state_d;
    logic             start_q, start_d;
    logic             step_q, step_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       committed_q, committed_d;
    logic [SBITS-1:0] seed_q, seed_d;
    logic [SBITS-1:0] score_q, score_d;
    logic [SBITS-1:0] best_q, best_d;
    logic             btn_start_q;

    logic             start_edge;
    logic             timer_clear;
    logic             timer_run;
    logic             expire;
    logic [2:0]       req;
    logic [SBITS-1:0] score_now;

    assign start_edge = btn_start && !btn_start_q;
    assign timer_run  = (state_q == ST_RUN) && !start_edge;
    assign score_now  = (snake_len > SBITS'(INIT_LEN)) ? snake_len - SBITS'(INIT_LEN) : '0;

    snake_step_timer #(
        .SBITS       (SBITS),
        .BASE_PERIOD (BASE_PERIOD),
        .SPEEDUP     (SPEEDUP),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .run       (timer_run),
        .snake_len (snake_len),
        .expire    (expire)
    );

    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        step_d      = 1'b0;
        dir_d       = dir_q;
        committed_d = committed_q;
        best_d      = best_q;
        timer_clear = 1'b0;
        req         = dir_request(btn_up, btn_right, btn_down, btn_left);
        seed_d      = (seed_q == SBITS'(CELLS - 1)) ? '0 : seed_q + 1'b1;
        score_d     = (state_q == ST_IDLE) ? '0 : score_now;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_d     = ST_RUN;
                    start_d     = 1'b1;
                    dir_d       = DIR_RIGHT;
                    committed_d = DIR_RIGHT;
                    timer_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (start_edge) begin
                    state_d = ST_PAUSE;
                end else begin
                    // Only a reversal of the last committed move is refused.
                    if (req[2] && ((req[1:0] ^ committed_q) != 2'd2))
                        dir_d = req[1:0];
                    if (expire) begin
                        if (snake_alive) begin
                            step_d      = 1'b1;
                            committed_d = dir_d;
                        end else begin
                            state_d = ST_OVER;
                            best_d  = (score_now > best_q) ? score_now : best_q;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (start_edge)
                    state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            step_q      <= 1'b0;
            dir_q       <= DIR_RIGHT;
            committed_q <= DIR_RIGHT;
            seed_q      <= '0;
            score_q     <= '0;
            best_q      <= '0;
            btn_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            committed_q <= committed_d;
            seed_q      <= seed_d;
            score_q     <= score_d;
            best_q      <= best_d;
            btn_start_q <= btn_start;
        end
    end

    assign start     = start_q;
    assign step      = step_q;
    assign snake_dir = dir_q;
    assign seed      = seed_q;
    assign state     = state_q;
    assign score     = score_q;
    assign best      = best_q;

endmodule
